// File: rtl/flash_read_arbiter.sv
// flash_read_arbiter: shares the qpi_flash read port between two byte requesters, with a one-entry result cache and SPI passthrough handover
module flash_read_arbiter #(
    parameter int BUSY_TIMEOUT = 8
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        a_req_i,
    input  logic [23:0] a_addr_i,
    output logic        a_ack_o,
    output logic [7:0]  a_data_o,
    input  logic        b_req_i,
    input  logic [23:0] b_addr_i,
    output logic        b_ack_o,
    output logic [7:0]  b_data_o,
    input  logic        pt_req_i,
    output logic        pt_grant_o,
    input  logic        flash_ready_i,
    input  logic [7:0]  flash_data_i,
    output logic        flash_read_o,
    output logic [23:0] flash_addr_o,
    output logic        flash_passthrough_o
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESPOND, PASSTHRU} state_t;
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);

    state_t        state_q;
    logic          rr_q;
    logic          owner_q;
    logic          cache_vld_q;
    logic [23:0]   cache_tag_q;
    logic [7:0]    cache_data_q;
    logic [CW-1:0] cnt_q;
    logic          a_ack_q;
    logic          b_ack_q;
    logic [7:0]    a_data_q;
    logic [7:0]    b_data_q;
    logic          flash_read_q;
    logic [23:0]   flash_addr_q;
    logic          pt_q;

    logic          sel_b;
    logic          any_req;
    logic          hit;
    logic [23:0]   sel_addr;
    logic [CW-1:0] cnt_d;

    // Round-robin pick (rr_q = 1 prefers B), cache lookup for the picked port, busy-wait count
    always_comb begin
        sel_b    = b_req_i && (!a_req_i || rr_q);
        any_req  = a_req_i || b_req_i;
        sel_addr = sel_b ? b_addr_i : a_addr_i;
        hit      = cache_vld_q && (sel_addr == cache_tag_q);
        cnt_d    = cnt_q + 1'b1;
    end

    // Arbitration FSM; every output is a register so acks and the read strobe are glitch-free
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q      <= IDLE;
            rr_q         <= 1'b0;
            owner_q      <= 1'b0;
            cache_vld_q  <= 1'b0;
            cache_tag_q  <= '0;
            cache_data_q <= '0;
            cnt_q        <= '0;
            a_ack_q      <= 1'b0;
            b_ack_q      <= 1'b0;
            a_data_q     <= '0;
            b_data_q     <= '0;
            flash_read_q <= 1'b0;
            flash_addr_q <= '0;
            pt_q         <= 1'b0;
        end else begin
            a_ack_q      <= 1'b0;
            b_ack_q      <= 1'b0;
            flash_read_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (pt_req_i && flash_ready_i) begin
                        state_q     <= PASSTHRU;
                        pt_q        <= 1'b1;
                        cache_vld_q <= 1'b0;
                    end else if (any_req && hit) begin
                        state_q <= RESPOND;
                        owner_q <= sel_b;
                        a_ack_q <= !sel_b;
                        b_ack_q <= sel_b;
                        if (sel_b) b_data_q <= cache_data_q;
                        else       a_data_q <= cache_data_q;
                    end else if (any_req && flash_ready_i) begin
                        state_q      <= ISSUE;
                        owner_q      <= sel_b;
                        flash_addr_q <= sel_addr;
                        flash_read_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (!flash_ready_i) begin
                        state_q <= WAIT_DONE;
                    end else if (cnt_d == CW'(BUSY_TIMEOUT)) begin
                        state_q      <= ISSUE;
                        flash_read_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                WAIT_DONE: begin
                    if (flash_ready_i) begin
                        state_q      <= RESPOND;
                        cache_vld_q  <= 1'b1;
                        cache_tag_q  <= flash_addr_q;
                        cache_data_q <= flash_data_i;
                        a_ack_q      <= !owner_q;
                        b_ack_q      <= owner_q;
                        if (owner_q) b_data_q <= flash_data_i;
                        else         a_data_q <= flash_data_i;
                    end
                end
                RESPOND: begin
                    rr_q    <= !owner_q;
                    state_q <= IDLE;
                end
                PASSTHRU: begin
                    if (!pt_req_i) begin
                        state_q <= IDLE;
                        pt_q    <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign a_ack_o             = a_ack_q;
    assign b_ack_o             = b_ack_q;
    assign a_data_o            = a_data_q;
    assign b_data_o            = b_data_q;
    assign flash_read_o        = flash_read_q;
    assign flash_addr_o        = flash_addr_q;
    assign pt_grant_o          = pt_q;
    assign flash_passthrough_o = pt_q;
endmodule

// File: tb/tb_flash_read_arbiter.sv
// tb_flash_read_arbiter: scoreboard bench with a behavioural flash model for flash_read_arbiter
module tb_flash_read_arbiter;
    localparam int BT = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        a_req = 1'b0;
    logic        b_req = 1'b0;
    logic        pt_req = 1'b0;
    logic [23:0] a_addr = '0;
    logic [23:0] b_addr = '0;
    logic        flash_ready = 1'b1;
    logic [7:0]  flash_data = '0;
    logic        a_ack;
    logic        b_ack;
    logic [7:0]  a_data;
    logic [7:0]  b_data;
    logic        pt_grant;
    logic        flash_read;
    logic [23:0] flash_addr;
    logic        flash_passthrough;

    int compared = 0;
    int mismatched = 0;
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    int ack_log[$];
    int acks_a = 0;
    int acks_b = 0;

    int          reads_seen = 0;
    int          ignore_at = 0;
    int          cyc = 0;
    int          last_strobe = -100;
    int          last_gap = 0;
    logic [23:0] last_addr = '0;
    logic        stuck = 1'b1;
    logic        long_busy = 1'b0;
    logic        m_act = 1'b0;
    logic        m_rdy = 1'b1;
    int          m_t = 0;
    int          m_d = 0;
    int          m_l = 0;
    logic [23:0] m_cur = '0;
    logic [7:0]  prev_a = '0;
    logic [7:0]  prev_b = '0;

    flash_read_arbiter #(.BUSY_TIMEOUT(BT)) dut (
        .clk_i              (clk),
        .reset_n_i          (reset_n),
        .a_req_i            (a_req),
        .a_addr_i           (a_addr),
        .a_ack_o            (a_ack),
        .a_data_o           (a_data),
        .b_req_i            (b_req),
        .b_addr_i           (b_addr),
        .b_ack_o            (b_ack),
        .b_data_o           (b_data),
        .pt_req_i           (pt_req),
        .pt_grant_o         (pt_grant),
        .flash_ready_i      (flash_ready),
        .flash_data_i       (flash_data),
        .flash_read_o       (flash_read),
        .flash_addr_o       (flash_addr),
        .flash_passthrough_o(flash_passthrough)
    );

    always #5 clk = ~clk;

    // Flash contents: a fixed function of the byte address
    function automatic logic [7:0] mem(input logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hD9;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // qpi_flash stand-in: on each strobe, optionally ignore it, else go busy after a random delay and return mem(addr)
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (flash_read) begin
                reads_seen++;
                last_gap = cyc - last_strobe;
                last_strobe = cyc;
                last_addr = flash_addr;
                if (reads_seen != ignore_at) begin
                    m_act = 1'b1;
                    m_t = 0;
                    m_d = $urandom_range(0, 2);
                    m_l = long_busy ? 20 : $urandom_range(1, 5);
                    m_cur = flash_addr;
                end
            end
            if (m_act) begin
                if (m_t >= m_d && m_t < m_d + m_l) m_rdy = 1'b0;
                else if (m_t == m_d + m_l) begin
                    m_rdy = 1'b1;
                    flash_data = mem(m_cur);
                    m_act = 1'b0;
                end
                m_t++;
            end
            flash_ready = m_rdy && !stuck;
        end
    end

    // Monitor: pops the expected byte on every ack, checks reset values and output invariants
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!reset_n) begin
                chk("reset_outputs", {a_ack, b_ack, pt_grant, flash_passthrough, flash_read, a_data, b_data, flash_addr}, 64'd0);
            end else begin
                chk("pt_mirror", flash_passthrough, pt_grant);
                if (flash_read) chk("read_during_pt", pt_grant, 1'b0);
                if (a_ack) begin
                    acks_a++;
                    ack_log.push_back(0);
                    if (exp_a.size() == 0) chk("a_unexpected_ack", a_ack, 1'b0);
                    else chk("a_data", a_data, exp_a.pop_front());
                end else chk("a_data_hold", a_data, prev_a);
                if (b_ack) begin
                    acks_b++;
                    ack_log.push_back(1);
                    if (exp_b.size() == 0) chk("b_unexpected_ack", b_ack, 1'b0);
                    else chk("b_data", b_data, exp_b.pop_front());
                end else chk("b_data_hold", b_data, prev_b);
            end
            prev_a = a_data;
            prev_b = b_data;
        end
    end

    task automatic req_a(input logic [23:0] addr, output int lat);
        @(negedge clk);
        a_req = 1'b1;
        a_addr = addr;
        exp_a.push_back(mem(addr));
        @(negedge clk);
        lat = 1;
        while (!a_ack && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        if (!a_ack) begin
            chk("a_ack_timeout", a_ack, 1'b1);
            void'(exp_a.pop_back());
        end
        a_req = 1'b0;
    endtask

    task automatic req_b(input logic [23:0] addr, output int lat);
        @(negedge clk);
        b_req = 1'b1;
        b_addr = addr;
        exp_b.push_back(mem(addr));
        @(negedge clk);
        lat = 1;
        while (!b_ack && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        if (!b_ack) begin
            chk("b_ack_timeout", b_ack, 1'b1);
            void'(exp_b.pop_back());
        end
        b_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int la;
        int lb;
        int r0;
        int a0;
        int b0;
        int n;
        logic [23:0] pool [4];
        pool[0] = 24'h000100;
        pool[1] = 24'h000101;
        pool[2] = 24'h000200;
        pool[3] = 24'h123454;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Ready gating after reset
        fork
            req_a(24'h123454, lat);
            begin
                repeat (50) @(negedge clk);
                chk("gated_no_read", reads_seen, 0);
                stuck = 1'b0;
            end
        join
        chk("gated_one_read", reads_seen, 1);
        chk("gated_addr", last_addr, 24'h123454);

        // Cache hit then neighbouring miss
        r0 = reads_seen;
        req_a(24'h123454, lat);
        chk("hit_latency", lat, 1);
        chk("hit_no_read", reads_seen, r0);
        req_a(24'h123455, lat);
        chk("miss_read", reads_seen, r0 + 1);
        chk("miss_addr", last_addr, 24'h123455);

        // Passthrough requested mid-read
        fork
            req_a(24'h00ABCD, lat);
            begin
                repeat (3) @(negedge clk);
                pt_req = 1'b1;
            end
        join
        chk("pt_after_read", pt_grant, 1'b0);
        repeat (2) @(negedge clk);
        chk("pt_grant", pt_grant, 1'b1);
        chk("pt_passthrough", flash_passthrough, 1'b1);
        r0 = reads_seen;
        b0 = acks_b;
        fork
            req_b(24'h00ABCD, lb);
            begin
                repeat (12) @(negedge clk);
                chk("pt_no_ack", acks_b, b0);
                chk("pt_no_read", reads_seen, r0);
                pt_req = 1'b0;
                @(negedge clk);
                chk("pt_release", pt_grant, 1'b0);
            end
        join
        chk("pt_cache_invalid", reads_seen, r0 + 1);

        // Busy timeout retry
        r0 = reads_seen;
        a0 = acks_a;
        ignore_at = reads_seen + 1;
        req_a(24'h0F0F0F, lat);
        repeat (3) @(negedge clk);
        chk("retry_reads", reads_seen, r0 + 2);
        chk("retry_gap", last_gap, BT + 1);
        chk("retry_single_ack", acks_a, a0 + 1);

        // Reset while waiting for flash data
        req_a(24'h3C3C3C, lat);
        long_busy = 1'b1;
        b0 = acks_b;
        r0 = reads_seen;
        @(negedge clk);
        b_req = 1'b1;
        b_addr = 24'h777777;
        n = 0;
        while (flash_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rst_read_issued", reads_seen, r0 + 1);
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        b_req = 1'b0;
        long_busy = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_no_ack", acks_b, b0);
        r0 = reads_seen;
        req_a(24'h3C3C3C, lat);
        chk("rst_cache_invalid", reads_seen, r0 + 1);

        // Round robin from a fresh reset
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        ack_log.delete();
        fork
            repeat (4) req_a(24'h000100, la);
            repeat (4) req_b(24'h000200, lb);
        join
        chk("rr_count", ack_log.size(), 8);
        for (int i = 0; i < 8; i++) chk("rr_order", (i < ack_log.size()) ? ack_log[i] : 9, i % 2);

        // Randomized traffic with occasional passthrough bursts
        for (int k = 0; k < 25; k++) begin
            fork
                if ($urandom_range(0, 3) != 0) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    req_a(pool[$urandom_range(0, 3)], la);
                end
                if ($urandom_range(0, 3) != 0) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    req_b(pool[$urandom_range(0, 3)], lb);
                end
                if ($urandom_range(0, 4) == 0) begin
                    repeat ($urandom_range(0, 4)) @(negedge clk);
                    pt_req = 1'b1;
                    repeat ($urandom_range(1, 6)) @(negedge clk);
                    pt_req = 1'b0;
                end
            join
        end

        repeat (5) @(negedge clk);
        chk("a_queue_empty", exp_a.size(), 0);
        chk("b_queue_empty", exp_b.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/flash_read_arbiter.md
# flash_read_arbiter

Shares the single read port of the QPI flash controller between two byte-read requesters: port A (CPU ROM fetch) and port B (secondary fetcher, e.g. ROM-to-RAM copy). It also hands the flash over to the external SPI passthrough path on request. A one-entry result cache answers repeated reads of the last fetched address without a flash transaction. The block sits between the requesters and `qpi_flash`, driving that block's `read`/`addr`/`passthrough` and consuming its `ready`/`data_out`.

## Interface
- `BUSY_TIMEOUT`, 8: cycles to wait for `flash_ready` to fall after a read pulse before the read is reissued.
- `clk` in 1: sole clock.
- `reset_n` in 1: synchronous, active-low reset.
- `a_req` in 1: port A read request (level).
- `a_addr` in 24: port A byte address.
- `a_ack` out 1: one-cycle pulse; `a_data` valid.
- `a_data` out 8: port A read data; held until the next `a_ack`.
- `b_req`, `b_addr`, `b_ack`, `b_data`: same as port A, for port B.
- `pt_req` in 1: passthrough request (level).
- `pt_grant` out 1: passthrough active.
- `flash_ready` in 1: `qpi_flash.ready`.
- `flash_data` in 8: `qpi_flash.data_out`.
- `flash_read` out 1: one-cycle read strobe to `qpi_flash`.
- `flash_addr` out 24: address to `qpi_flash`; registered.
- `flash_passthrough` out 1: drives `qpi_flash.passthrough`; equals `pt_grant`.

## Operation
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESPOND, PASSTHRU.
- **IDLE**, in priority order:
  - `pt_req` and `flash_ready` → PASSTHRU.
  - Otherwise select a requester by round-robin between A and B. `rr` points at the preferred port; on a tie the preferred port wins, and `rr` flips to the other port after that port is served. If only one port requests, it is served.
  - Cache hit (cache valid and selected addr == cached addr) → RESPOND with cached data. No flash access.
  - Cache miss and `flash_ready` = 1 → latch `flash_addr` and the owner port → ISSUE.
  - Miss with `flash_ready` = 0 → stay in IDLE.
- **ISSUE**: `flash_read` = 1 for exactly this cycle; clear the timeout counter → WAIT_BUSY.
- **WAIT_BUSY**:
  - `flash_ready` = 0 → WAIT_DONE.
  - Counter reaches `BUSY_TIMEOUT` with ready still 1 → ISSUE (retry, same address).
- **WAIT_DONE**: first cycle with `flash_ready` = 1 → capture `flash_data` into the owner's data register and into the cache (tag = `flash_addr`, valid = 1) → RESPOND.
- **RESPOND**: owner's ack = 1 for this cycle only → IDLE.
- **PASSTHRU**:
  - `pt_grant` = `flash_passthrough` = 1; cache invalidated on entry. Read requests stall with no acks.
  - `pt_req` = 0 → IDLE. The cache stays invalid, so the next read goes to flash.
- **Requester contract**:
  - Hold `req` and `addr` stable until ack; drop `req` in the cycle after ack.
  - `req` still high in the cycle after ack counts as a new request; it normally hits the cache.
  - Dropping `req` before ack is illegal; the transaction still completes and acks.
- **Simultaneous events**:
  - `pt_req` arriving during a read does not abort it; passthrough is granted on the next IDLE.
  - `pt_req` beats pending reads in IDLE.
  - The data register of the non-owner port never changes.
- **Reset** (`reset_n` = 0 at a clock edge), including mid-transaction:
  - State goes to IDLE; cache invalid; `rr` points at A.
  - All outputs 0 (`a_data`, `b_data`, `flash_addr` included).
  - No ack is emitted for an aborted transaction.

## Timing
- Cache hit: `req` seen in IDLE at cycle N → ack at N+1.
- Miss: IDLE at N → `flash_read` at N+1 → WAIT_BUSY from N+2. Ready rises at cycle M in WAIT_DONE → data captured at the M edge → ack at M+1.
- Back-to-back misses: earliest next `flash_read` is 2 cycles after ack (RESPOND → IDLE → ISSUE).
- Passthrough: `pt_req` seen in IDLE at N → `pt_grant` at N+1. `pt_req` low at K → `pt_grant` low at K+1.
- `flash_read` is never asserted while `pt_grant` = 1 or `flash_ready` = 0 at issue decision.

## Test plan
- **Post-reset ready gating.** Hold `flash_ready` = 0 for 50 cycles with `a_req` = 1, addr 0x123454 → no `flash_read`. Ready rises → single `flash_read` with `flash_addr` = 0x123454. Model returns 0xAB → `a_ack` pulse with `a_data` = 0xAB.
- **Cache hit.** Re-request A at 0x123454 → `a_ack` one cycle after sampling, `a_data` = 0xAB, no `flash_read`. Request 0x123455 → flash read issued.
- **Round-robin.** `a_req` and `b_req` high together at 0x000100 and 0x000200, with each request re-raised after its ack → acks alternate A, B, A, B. `b_data` tracks 0x000200's byte; `a_data` is unaffected by B transactions.
- **Passthrough.** Raise `pt_req` mid-read → read acks first, then `pt_grant` = `flash_passthrough` = 1. A request meanwhile gets no ack. Drop `pt_req` → the pending request misses the cache and issues `flash_read` even for the previously cached address.
- **Timeout retry.** Model keeps `flash_ready` = 1 after the first strobe → a second `flash_read` exactly `BUSY_TIMEOUT` + 1 cycles after the first. A normal response then gives exactly one ack.
- **Reset mid-read.** Pulse `reset_n` low while in WAIT_DONE → all outputs 0, no ack. The next request for the same addr misses the cache.
